// File: rtl/alu_core_pkg.sv
// alu_core_pkg: opcode, FSM state and instruction-field definitions shared by the ALU core
package alu_core_pkg;

    localparam int INSTR_W  = 28;
    localparam int OP_W     = 4;
    localparam int FIELD_W  = 8;
    localparam int OP_LSB   = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC0_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_STO  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_BLE  = 4'd4,
        OP_JMP  = 4'd5,
        OP_LED  = 4'd6,
        OP_SHL  = 4'd7,
        OP_MUL  = 4'd8,
        OP_CALL = 4'd9,
        OP_RET  = 4'd10,
        OP_HALT = 4'd11
    } opcodeT;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_HALT = 2'd2
    } stateT;

endpackage

// File: rtl/seq_mul.sv
// seq_mul: unsigned shift-add multiplier retiring one partial product per enabled cycle
module seq_mul #(
    parameter int DATA_W = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                en,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mcand;
    logic [CNT_W-1:0]  count;
    logic [DATA_W:0]   partial;

    assign done    = count == CNT_W'(DATA_W);
    // the multiplier sits in the low half and shifts out as the product grows in from the top
    assign partial = {1'b0, product[2*DATA_W-1:DATA_W]} + {1'b0, mcand & {DATA_W{product[0]}}};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mcand   <= '0;
            count   <= '0;
            product <= '0;
        end else if (start) begin
            mcand   <= a;
            count   <= '0;
            product <= {{DATA_W{1'b0}}, b};
        end else if (en && !done) begin
            count   <= count + CNT_W'(1);
            product <= {partial, product[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/alu_core_param.sv
// alu_core_param: single-issue sequencer with register file, return stack and multi-cycle multiply
module alu_core_param
    import alu_core_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int REG_AW      = 3,
    parameter int STACK_DEPTH = 4,
    parameter int LED_W       = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iRun,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [ADDR_W-1:0]  oIP,
    output logic [LED_W-1:0]   oLed,
    output logic               oBusy,
    output logic               oHalted,
    output logic               oStackErr
);

    localparam int RA_W  = REG_AW > 0 ? REG_AW : 1;
    localparam int NREG  = 2 ** RA_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int SLOTS = 2 ** SP_W;

    stateT                state, nextState;
    logic [DATA_W-1:0]    regFile [NREG];
    logic [ADDR_W-1:0]    retStack [SLOTS];
    logic [SP_W-1:0]      sp;
    logic [OP_W-1:0]      op;
    logic [FIELD_W-1:0]   dst, src1, src0;
    logic [RA_W-1:0]      dstIdx, mulDst, mulHiIdx;
    logic [DATA_W-1:0]    opA, opB;
    logic [ADDR_W-1:0]    ipNext, target;
    logic [2*DATA_W-1:0]  product;
    logic                 stackFull, stackEmpty, issue, mulStart, mulDone, mulFinish, stackErr;

    function automatic logic [RA_W-1:0] regIdx(input logic [FIELD_W-1:0] addr);
        return REG_AW > 0 ? addr[RA_W-1:0] : '0;
    endfunction

    assign op         = iInstruction[OP_LSB +: OP_W];
    assign dst        = iInstruction[DST_LSB +: FIELD_W];
    assign src1       = iInstruction[SRC1_LSB +: FIELD_W];
    assign src0       = iInstruction[SRC0_LSB +: FIELD_W];
    assign dstIdx     = regIdx(dst);
    assign opA        = regFile[regIdx(src1)];
    assign opB        = regFile[regIdx(src0)];
    assign ipNext     = oIP + ADDR_W'(1);
    assign target     = ADDR_W'(dst);
    assign stackFull  = sp == SP_W'(STACK_DEPTH);
    assign stackEmpty = sp == '0;
    assign issue      = state == ST_RUN && iRun;
    assign mulStart   = issue && op == OP_MUL;
    assign mulFinish  = state == ST_MUL && iRun && mulDone;
    assign mulHiIdx   = REG_AW > 0 ? mulDst + RA_W'(1) : mulDst;
    assign oBusy      = state == ST_MUL;
    assign oHalted    = state == ST_HALT;

    seq_mul #(.DATA_W(DATA_W)) mulUnit (
        .Clock  (Clock),
        .Reset  (Reset),
        .start  (mulStart),
        .a      (opA),
        .b      (opB),
        .en     (state == ST_MUL && iRun),
        .done   (mulDone),
        .product(product)
    );

    always_comb begin
        nextState = state;
        stackErr  = 1'b0;
        if (issue) begin
            stackErr  = (op == OP_CALL && stackFull) || (op == OP_RET && stackEmpty);
            nextState = op == OP_MUL ? ST_MUL : (op == OP_HALT || stackErr) ? ST_HALT : ST_RUN;
        end else if (mulFinish) begin
            nextState = ST_RUN;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            state <= ST_RUN;
        else
            state <= nextState;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oIP       <= '0;
            oLed      <= '0;
            oStackErr <= 1'b0;
            sp        <= '0;
            mulDst    <= '0;
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
            for (int i = 0; i < SLOTS; i++) retStack[i] <= '0;
        end else if (mulFinish) begin
            // low half is written last so it wins when both halves alias one register
            regFile[mulHiIdx] <= product[2*DATA_W-1:DATA_W];
            regFile[mulDst]   <= product[DATA_W-1:0];
            oIP               <= ipNext;
        end else if (issue) begin
            oStackErr <= oStackErr || stackErr;
            case (op)
                OP_STO: begin
                    regFile[dstIdx] <= DATA_W'({src1, src0});
                    oIP             <= ipNext;
                end
                OP_ADD: begin
                    regFile[dstIdx] <= opA + opB;
                    oIP             <= ipNext;
                end
                OP_SUB: begin
                    regFile[dstIdx] <= opA - opB;
                    oIP             <= ipNext;
                end
                OP_BLE: oIP <= (opA <= opB) ? target : ipNext;
                OP_JMP: oIP <= target;
                OP_LED: begin
                    oLed <= opA[LED_W-1:0];
                    oIP  <= ipNext;
                end
                OP_SHL: begin
                    regFile[dstIdx] <= opA << opB;
                    oIP             <= ipNext;
                end
                OP_MUL: mulDst <= dstIdx;
                OP_CALL: begin
                    if (!stackFull) begin
                        retStack[sp] <= ipNext;
                        sp           <= sp + SP_W'(1);
                        oIP          <= target;
                    end
                end
                OP_RET: begin
                    if (!stackEmpty) begin
                        oIP <= retStack[sp - SP_W'(1)];
                        sp  <= sp - SP_W'(1);
                    end
                end
                OP_HALT: ;
                default: oIP <= ipNext;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_core_param.sv
// tb_alu_core_param: directed and random programs on two configurations, checked each cycle against an ISA-level model
module tb_alu_core_param;

    typedef struct packed {
        logic [15:0] ip;
        logic [7:0]  led;
        logic        busy;
        logic        halted;
        logic        err;
    } obsT;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic [1:0] rstN = 2'b00;
    logic [1:0] run = 2'b00;
    logic [27:0] rom0 [256];
    logic [27:0] rom1 [256];
    logic [27:0] instr0, instr1;
    logic [15:0] ip0;
    logic [7:0]  ip1, led0, led1;
    logic        busy0, halted0, err0, busy1, halted1, err1;

    always #5 clk = ~clk;

    assign instr0 = rom0[ip0[7:0]];
    assign instr1 = rom1[ip1];

    alu_core_param dut0 (
        .Clock(clk), .Reset(rstN[0]), .iRun(run[0]), .iInstruction(instr0),
        .oIP(ip0), .oLed(led0), .oBusy(busy0), .oHalted(halted0), .oStackErr(err0)
    );

    alu_core_param #(.DATA_W(8), .ADDR_W(8), .REG_AW(2), .STACK_DEPTH(DEPTH), .LED_W(8)) dut1 (
        .Clock(clk), .Reset(rstN[1]), .iRun(run[1]), .iInstruction(instr1),
        .oIP(ip1), .oLed(led1), .oBusy(busy1), .oHalted(halted1), .oStackErr(err1)
    );

    int unsigned dw [2]   = '{16, 8};
    int unsigned nreg [2] = '{8, 4};
    longint unsigned amask [2] = '{64'hFFFF, 64'hFF};
    longint unsigned mR [2][8];
    longint unsigned mStk [2][DEPTH];
    longint unsigned mIp [2], mLed [2], mProd [2];
    int  mSp [2], mMulLeft [2], mMulDst [2];
    bit  mHalt [2], mErr [2];
    obsT q0 [$];
    obsT q1 [$];
    int  vectors = 0;
    int  miscompares = 0;

    function automatic logic [27:0] ins(int op, int d, int s1, int s0);
        return {4'(op), 8'(d), 8'(s1), 8'(s0)};
    endfunction

    function automatic obsT observe(int k);
        obsT o;
        o = (k == 0) ? {ip0, led0, busy0, halted0, err0} : {8'h00, ip1, led1, busy1, halted1, err1};
        return o;
    endfunction

    task automatic check(string name, obsT got, obsT want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got ip=%0h led=%0h busy=%b halt=%b err=%b, want ip=%0h led=%0h busy=%b halt=%b err=%b",
                     name, $time, got.ip, got.led, got.busy, got.halted, got.err,
                     want.ip, want.led, want.busy, want.halted, want.err);
        end
    endtask

    task automatic checkVal(string name, longint unsigned got, longint unsigned want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic modelReset(int k);
        for (int i = 0; i < 8; i++) mR[k][i] = 0;
        for (int i = 0; i < DEPTH; i++) mStk[k][i] = 0;
        mIp[k] = 0; mLed[k] = 0; mProd[k] = 0;
        mSp[k] = 0; mMulLeft[k] = 0; mMulDst[k] = 0;
        mHalt[k] = 0; mErr[k] = 0;
    endtask

    // one clock of ISA behaviour; MUL simply occupies DATA_W+1 running cycles before retiring
    task automatic modelStep(int k, bit r);
        logic [27:0] w;
        int op, d, s1, s0, n;
        longint unsigned a, b, m, inc;
        obsT e;
        n   = int'(nreg[k]);
        m   = (64'd1 << dw[k]) - 1;
        w   = (k == 0) ? rom0[mIp[k] % 256] : rom1[mIp[k] % 256];
        op  = int'(w[27:24]); d = int'(w[23:16]); s1 = int'(w[15:8]); s0 = int'(w[7:0]);
        a   = mR[k][s1 % n];
        b   = mR[k][s0 % n];
        inc = (mIp[k] + 1) & amask[k];
        if (!mHalt[k] && r) begin
            if (mMulLeft[k] > 0) begin
                mMulLeft[k]--;
                if (mMulLeft[k] == 0) begin
                    mR[k][(mMulDst[k] + 1) % n] = (mProd[k] >> dw[k]) & m;
                    mR[k][mMulDst[k] % n] = mProd[k] & m;
                    mIp[k] = inc;
                end
            end else begin
                case (op)
                    1: begin mR[k][d % n] = ((s1 << 8) | s0) & m; mIp[k] = inc; end
                    2: begin mR[k][d % n] = (a + b) & m; mIp[k] = inc; end
                    3: begin mR[k][d % n] = (a - b) & m; mIp[k] = inc; end
                    4: mIp[k] = (a <= b) ? longint'(d) : inc;
                    5: mIp[k] = d;
                    6: begin mLed[k] = a & 64'hFF; mIp[k] = inc; end
                    7: begin mR[k][d % n] = (b >= dw[k]) ? 0 : (a << b) & m; mIp[k] = inc; end
                    8: begin mProd[k] = a * b; mMulLeft[k] = int'(dw[k]) + 1; mMulDst[k] = d; end
                    9: if (mSp[k] == DEPTH) begin
                           mErr[k] = 1; mHalt[k] = 1;
                       end else begin
                           mStk[k][mSp[k]] = inc; mSp[k]++; mIp[k] = d;
                       end
                    10: if (mSp[k] == 0) begin
                            mErr[k] = 1; mHalt[k] = 1;
                        end else begin
                            mSp[k]--; mIp[k] = mStk[k][mSp[k]];
                        end
                    11: mHalt[k] = 1;
                    default: mIp[k] = inc;
                endcase
            end
        end
        e.ip = 16'(mIp[k]); e.led = 8'(mLed[k]);
        e.busy = mMulLeft[k] > 0; e.halted = mHalt[k]; e.err = mErr[k];
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic monitor();
        obsT e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin e = q0.pop_front(); check("dut0 cycle", observe(0), e); end
            if (q1.size() > 0) begin e = q1.pop_front(); check("dut1 cycle", observe(1), e); end
        end
    endtask

    task automatic setRom(int k, int addr, logic [27:0] v);
        if (k == 0) rom0[addr] = v; else rom1[addr] = v;
    endtask

    task automatic clearRom(int k);
        for (int i = 0; i < 256; i++) setRom(k, i, '0);
    endtask

    task automatic randProg(int k);
        int op, d;
        clearRom(k);
        for (int i = 0; i < 32; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 11 && $urandom_range(0, 3) != 0) op = 0;
            d = (op == 4 || op == 5 || op == 9) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 255));
            setRom(k, i, ins(op, d, int'($urandom_range(0, 255)), int'($urandom_range(0, 255))));
        end
    endtask

    // entered and left at 2 time units after a rising edge
    task automatic runProg(int k, int cycles, int runPct, int resetAt);
        bit r;
        rstN[k] = 1'b0;
        modelReset(k);
        repeat (2) @(posedge clk);
        #2;
        check("reset state", observe(k), '0);
        rstN[k] = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (c == resetAt) begin
                rstN[k] = 1'b0;
                #1;
                check("async reset", observe(k), '0);
                modelReset(k);
                @(posedge clk);
                #2;
                rstN[k] = 1'b1;
            end
            r = $urandom_range(0, 99) < runPct;
            run[k] = r;
            modelStep(k, r);
            @(posedge clk);
            #2;
        end
        for (int i = 0; i < int'(nreg[k]); i++)
            checkVal($sformatf("dut%0d R%0d", k, i), (k == 0) ? longint'(dut0.regFile[i]) : longint'(dut1.regFile[i]), mR[k][i]);
        rstN[k] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clearRom(0);
        clearRom(1);
        fork monitor(); join_none
        @(posedge clk);
        #2;

        setRom(0, 0,  ins(1, 1, 8'h00, 8'h05));
        setRom(0, 1,  ins(1, 2, 8'h00, 8'h03));
        setRom(0, 2,  ins(2, 3, 1, 2));
        setRom(0, 3,  ins(6, 0, 3, 0));
        setRom(0, 4,  ins(3, 4, 2, 1));
        setRom(0, 5,  ins(6, 0, 4, 0));
        setRom(0, 6,  ins(1, 0, 0, 16));
        setRom(0, 7,  ins(7, 5, 1, 0));
        setRom(0, 8,  ins(6, 0, 5, 0));
        setRom(0, 9,  ins(4, 12, 2, 1));
        setRom(0, 10, ins(11, 0, 0, 0));
        setRom(0, 11, ins(11, 0, 0, 0));
        setRom(0, 12, ins(4, 10, 1, 2));
        setRom(0, 13, ins(1, 6, 8'hFF, 8'hFF));
        setRom(0, 14, ins(8, 6, 6, 6));
        setRom(0, 15, ins(6, 0, 6, 0));
        setRom(0, 16, ins(6, 0, 7, 0));
        setRom(0, 17, ins(9, 20, 0, 0));
        setRom(0, 18, ins(11, 0, 0, 0));
        setRom(0, 20, ins(8, 7, 1, 2));
        setRom(0, 21, ins(6, 0, 7, 0));
        setRom(0, 22, ins(10, 0, 0, 0));
        runProg(0, 80, 100, -1);
        runProg(0, 140, 70, -1);

        clearRom(0);
        for (int i = 0; i < 5; i++) setRom(0, i, ins(9, i + 1, 0, 0));
        runProg(0, 12, 100, -1);

        clearRom(0);
        setRom(0, 0,  ins(9, 10, 0, 0));
        setRom(0, 1,  ins(11, 0, 0, 0));
        setRom(0, 10, ins(9, 20, 0, 0));
        setRom(0, 11, ins(10, 0, 0, 0));
        setRom(0, 20, ins(9, 30, 0, 0));
        setRom(0, 21, ins(10, 0, 0, 0));
        setRom(0, 30, ins(9, 40, 0, 0));
        setRom(0, 31, ins(10, 0, 0, 0));
        setRom(0, 40, ins(10, 0, 0, 0));
        runProg(0, 16, 100, -1);

        clearRom(0);
        setRom(0, 1, ins(10, 0, 0, 0));
        runProg(0, 6, 100, -1);

        clearRom(0);
        setRom(0, 0, ins(1, 1, 8'h12, 8'h34));
        setRom(0, 1, ins(8, 2, 1, 1));
        setRom(0, 2, ins(6, 0, 2, 0));
        setRom(0, 3, ins(6, 0, 3, 0));
        setRom(0, 4, ins(11, 0, 0, 0));
        runProg(0, 40, 100, 6);

        clearRom(1);
        setRom(1, 0,   ins(1, 1, 8'h12, 8'h34));
        setRom(1, 1,   ins(6, 0, 1, 0));
        setRom(1, 2,   ins(8, 3, 1, 1));
        setRom(1, 3,   ins(6, 0, 3, 0));
        setRom(1, 4,   ins(1, 2, 0, 8));
        setRom(1, 5,   ins(7, 0, 1, 2));
        setRom(1, 6,   ins(6, 0, 0, 0));
        setRom(1, 7,   ins(5, 8'hFF, 0, 0));
        setRom(1, 255, ins(0, 0, 0, 0));
        runProg(1, 40, 100, -1);
        runProg(1, 60, 60, -1);

        for (int t = 0; t < 3; t++) begin
            randProg(0);
            runProg(0, 150, 80, -1);
        end
        for (int t = 0; t < 3; t++) begin
            randProg(1);
            runProg(1, 150, 80, -1);
        end

        vectors++;
        if (q0.size() + q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_core_param.md
# alu_core_param

Parametrised successor to the 16-bit MiniAlu execution core: a single-issue sequencer that fetches 28-bit instructions from an asynchronous-read instruction ROM through `oIP`, executes them against an internal register file, and drives the LED port. It adds a configurable data/register/IP width, a return-address stack of configurable depth for nested CALL/RET, a multi-cycle shift-add multiplier with stall, an external run/stall input, HALT, and sticky error reporting. It sits between the instruction ROM and the board LEDs, replacing the fixed-width core.

## Interface
Parameters:
- `DATA_W`, default 16: register and ALU width (≥ 8).
- `ADDR_W`, default 16: IP width (≥ 8).
- `REG_AW`, default 3: register-address bits (2^REG_AW registers).
- `STACK_DEPTH`, default 4: return-stack entries (≥ 1).
- `LED_W`, default 8: LED width (≤ DATA_W).

Ports:
- `Clock`: input, 1 bit. Single clock; all state updates on the rising edge.
- `Reset`: input, 1 bit. Asynchronous, active-low.
- `iRun`: input, 1 bit. When 0, the core holds all state in RUN and MUL. HALT is unaffected.
- `iInstruction`: input, 28 bits. `[27:24]` opcode, `[23:16]` DST, `[15:8]` SRC1, `[7:0]` SRC0. Combinational ROM data for `oIP`.
- `oIP`: output, ADDR_W bits. Fetch address.
- `oLed`: output, LED_W bits. Registered LED value.
- `oBusy`: output, 1 bit. High in state MUL.
- `oHalted`: output, 1 bit. High in state HALT.
- `oStackErr`: output, 1 bit. Sticky flag for stack overflow or underflow.

## Operation
- Register operands use `addr[REG_AW-1:0]`. R[x] denotes a register.
- Jump targets are DST, zero-extended to ADDR_W.
- FSM states:
  - RUN → MUL on a MUL instruction.
  - MUL → RUN when the multiply completes.
  - RUN → HALT on HALT, or on a stack error.
  - HALT exits only via reset.
- Opcodes, decoded only in RUN with `iRun` = 1:
  - NOP (0): IP+1.
  - STO (1): R[DST] ← {SRC1,SRC0}, zero-extended or truncated to DATA_W.
  - ADD (2): R[DST] ← R[SRC1] + R[SRC0], mod 2^DATA_W.
  - SUB (3): R[DST] ← R[SRC1] − R[SRC0], mod 2^DATA_W.
  - BLE (4): if R[SRC1] ≤ R[SRC0] (unsigned), IP ← DST; otherwise IP+1.
  - JMP (5): IP ← DST.
  - LED (6): `oLed` ← R[SRC1][LED_W-1:0].
  - SHL (7): R[DST] ← R[SRC1] << R[SRC0]. A shift amount ≥ DATA_W gives 0.
  - MUL (8): unsigned R[SRC1] × R[SRC0]. Low half → R[DST], high half → R[DST+1] (register index wraps mod 2^REG_AW). Both writes occur on the final MUL cycle.
  - CALL (9):
    - Not full: push IP+1, IP ← DST.
    - Full: set `oStackErr`, enter HALT, IP unchanged.
  - RET (10):
    - Not empty: IP ← pop.
    - Empty: set `oStackErr`, enter HALT.
  - HALT (11): enter HALT, IP unchanged.
  - Opcodes 12–15: treated as NOP.
- Operand latching: MUL latches its operands at entry, so later register-file changes cannot alter the result.
- Stack storage: pushed values are full ADDR_W. The stack pointer counts 0..STACK_DEPTH.

## Timing
- Reset values (asynchronous): `oIP`, `oLed`, all registers, the stack pointer, the stack RAM and the multiplier state are 0. State is RUN. `oBusy`, `oHalted` and `oStackErr` are 0.
- Latency, non-MUL instruction: 1 cycle. The result, IP and LED update on the same edge.
- Latency, MUL: exactly DATA_W + 1 edges from the MUL edge in RUN to the edge that writes both registers and sets IP+1.
  - `oIP` holds the MUL address throughout.
  - `oBusy` is high for DATA_W + 1 cycles.
- `iRun` = 0 in MUL freezes the iteration counter. Latency extends by one cycle per stalled cycle.
- IP wraps from 2^ADDR_W − 1 to 0.
- A write to R[DST] is visible to the next instruction; there is no forwarding hazard.
- If a MUL has DST+1 == DST (REG_AW = 0), the low half wins.
- Reset asserted mid-MUL or in HALT takes effect immediately (asynchronous). Recovery begins on the first edge after deassertion.

## Structure
- Shared package `alu_core_pkg` (extends the existing definitions header) holds:
  - opcode constants;
  - FSM state encodings;
  - instruction field bit positions.
- Sub-module `seq_mul`: shift-add multiplier with ports `start`, `a`, `b`, `en`, `done`, `product[2*DATA_W-1:0]`. It has its own counter.
- The register file, return stack and FSM stay in the top module.

## Test plan
- Reset, then STO R1←0x0005, STO R2←0x0003, ADD R3←R1+R2, LED R3 → `oLed` = 0x08 on the 4th edge; `oIP` = 4.
- SUB R4←R2−R1 (3 − 5) → R4 = 0xFFFE. SHL R5←R1<<16 → 0. BLE with R2 ≤ R1 → `oIP` = DST; with operands swapped → IP+1.
- MUL 0xFFFF × 0xFFFF with DST = 6 → after exactly 17 edges R6 = 0x0001, R7 = 0xFFFE. Toggling `iRun` low for 3 cycles mid-MUL → 20 edges.
- Five nested CALLs with STACK_DEPTH = 4 → the 5th sets `oStackErr` = 1 and `oHalted` = 1, with `oIP` frozen. A separate run of 4 CALLs and 4 RETs returns to each caller+1 in LIFO order.
- RET on an empty stack → `oStackErr` = 1 and HALT. `Reset` low mid-MUL → all outputs 0 immediately, and execution restarts at IP 0.
- DATA_W = 8, ADDR_W = 8, REG_AW = 2: STO 0x1234 → R = 0x34. JMP 0xFF then NOP → `oIP` wraps to 0x00.
